// File: rtl/pll_spi_pkg.sv
// Shared constants and state encoding for the PLL SPI responder.
package pll_spi_pkg;

    localparam int FRAME_W  = 32;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 28;
    localparam int NUM_REGS = 16;
    localparam int CNT_W    = 6;
    localparam int LOCK_W   = 24;

    localparam logic [ADDR_W-1:0] SOFT_RST_ADDR = 4'd5;
    localparam logic [CNT_W-1:0]  CNT_SAT       = 6'd33;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

endpackage

// File: rtl/pll_spi_responder_sync_edge.sv
// spi_sync_edge: multi-stage synchronizer with rise/fall detection on the
// synchronized level. Stages reset to 0 so a chip-select held low across
// reset release never produces a false falling edge.
module spi_sync_edge
    import pll_spi_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer and remember the last level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pll_spi_responder.sv
// pll_spi_responder: SPI (CPOL=0/CPHA=1) slave that writes 32-bit frames
// {payload[27:0], addr[3:0]} into a 16x28 register file and echoes the
// previously committed register on MISO. Optional macro
// PLL_SPI_RESP_LOCK_EN enables the emulated PLL lock counter; without it
// lock simply follows reset release.
module pll_spi_responder
    import pll_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_DELAY  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              reg_wr_valid,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              frame_err,
    output logic              soft_rst,
    output logic              lock,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .in_i(spi_cs),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .in_i(spi_sck),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .in_i(spi_mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

    // Only the cs edges, sck edges and mosi level carry meaning here.
    logic unused_sync;
    assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

    state_e              state_q;
    logic [FRAME_W-1:0]  shreg_q, out_sh_q;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   echo_q, wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                miso_q, valid_q, err_q, soft_q;

    logic [ADDR_W-1:0]   frm_addr;
    logic [DATA_W-1:0]   frm_data;
    logic [FRAME_W-1:0]  echo_word;
    logic                frame_good, soft_hit;

    assign frm_addr   = shreg_q[ADDR_W-1:0];
    assign frm_data   = shreg_q[FRAME_W-1:ADDR_W];
    assign echo_word  = {regs_q[echo_q], echo_q};
    assign frame_good = (state_q == ST_SHIFT) && cs_rise && (bit_cnt_q == CNT_W'(FRAME_W));
    assign soft_hit   = frame_good && (frm_addr == SOFT_RST_ADDR) && frm_data[0];

    // Bit counter sticks at 33 so overlong frames can never look like 32.
    always_comb begin
        bit_cnt_d = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 1'b1;
    end

    // Frame FSM: shifting, commit/error decision, register file and echo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            out_sh_q  <= '0;
            bit_cnt_q <= '0;
            echo_q    <= '0;
            miso_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            soft_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            soft_q  <= 1'b0;
            case (state_q)
                ST_SHIFT: begin
                    if (cs_rise) begin
                        miso_q <= 1'b0;
                        if (frame_good) begin
                            state_q   <= ST_COMMIT;
                            valid_q   <= 1'b1;
                            wr_addr_q <= frm_addr;
                            wr_data_q <= frm_data;
                            echo_q    <= frm_addr;
                            if (soft_hit) begin
                                soft_q <= 1'b1;
                                for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
                            end else begin
                                regs_q[frm_addr] <= frm_data;
                            end
                        end else begin
                            state_q <= ST_ERROR;
                            err_q   <= 1'b1;
                        end
                    end else if (!cs_lvl) begin
                        if (sck_fall) begin
                            shreg_q   <= {shreg_q[FRAME_W-2:0], mosi_lvl};
                            bit_cnt_q <= bit_cnt_d;
                        end
                        if (sck_rise) begin
                            miso_q   <= out_sh_q[FRAME_W-1];
                            out_sh_q <= {out_sh_q[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    // IDLE, COMMIT and ERROR all start a new frame on cs fall.
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= ST_SHIFT;
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        out_sh_q  <= echo_word;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    logic lock_q;

`ifdef PLL_SPI_RESP_LOCK_EN
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_DELAY - 1);

    logic [LOCK_W-1:0] lock_cnt_q;
    logic              lock_run_q;
    logic              r0_hit;

    assign r0_hit = frame_good && (frm_addr == '0);

    // Lock counter restarts on every R0 commit; soft reset stops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_run_q <= 1'b0;
            lock_q     <= 1'b0;
        end else if (soft_hit) begin
            lock_cnt_q <= '0;
            lock_run_q <= 1'b0;
            lock_q     <= 1'b0;
        end else if (r0_hit) begin
            lock_cnt_q <= '0;
            lock_run_q <= 1'b1;
            lock_q     <= 1'b0;
        end else if (lock_run_q) begin
            if (lock_cnt_q == LOCK_LAST) begin
                lock_q     <= 1'b1;
                lock_run_q <= 1'b0;
            end else begin
                lock_cnt_q <= lock_cnt_q + 1'b1;
            end
        end
    end
`else
    logic [LOCK_W-1:0] unused_lock_delay;
    assign unused_lock_delay = LOCK_W'(LOCK_DELAY);

    // Lock is simply released together with reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= 1'b1;
    end
`endif

    assign spi_miso     = miso_q;
    assign reg_wr_valid = valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign frame_err    = err_q;
    assign soft_rst     = soft_q;
    assign lock         = lock_q;
    assign rd_data      = regs_q[rd_addr];

endmodule

// File: tb/tb_pll_spi_responder.sv
// Bench for pll_spi_responder: randomized SPI frames against a behavioural
// register-file model; commit/error events checked by a scoreboard monitor.
module tb_pll_spi_responder;

    localparam int H  = 8;   // sck half period in clk cycles
    localparam int LD = 16;  // LOCK_DELAY used by this bench

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        reg_wr_valid;
    logic [3:0]  reg_wr_addr;
    logic [27:0] reg_wr_data;
    logic        frame_err;
    logic        soft_rst;
    logic        lock;
    logic [3:0]  rd_addr = 4'd0;
    logic [27:0] rd_data;

    pll_spi_responder #(.SYNC_STAGES(2), .LOCK_DELAY(LD)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_wr_valid(reg_wr_valid),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .frame_err(frame_err),
        .soft_rst(soft_rst), .lock(lock), .rd_addr(rd_addr), .rd_data(rd_data));

    // ---------------- clock / cycle counter ----------------
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    int commit_cyc = 0;

    // expected event: {kind[1:0], addr[3:0], data[27:0]}; kind 0=write, 1=soft reset, 2=error
    logic [33:0] exp_q[$];
    logic [27:0] m_regs [16];
    logic [3:0]  m_echo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 28'd0;
        m_echo = 4'd0;
    endfunction

    function automatic logic [31:0] model_echo_word();
        return {m_regs[m_echo], m_echo};
    endfunction

    function automatic void model_frame(input logic [31:0] word, input int nbits);
        logic [3:0]  a;
        logic [27:0] d;
        a = word[3:0];
        d = word[31:4];
        if (nbits != 32) begin
            exp_q.push_back({2'd2, 32'd0});
        end else if (a == 4'd5 && d[0]) begin
            exp_q.push_back({2'd1, a, d});
            for (int i = 0; i < 16; i++) m_regs[i] = 28'd0;
            m_echo = a;
        end else begin
            exp_q.push_back({2'd0, a, d});
            m_regs[a] = d;
            m_echo = a;
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [33:0] mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_valid || frame_err) begin
                if (reg_wr_valid) commit_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {62'd0, reg_wr_valid, frame_err}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind", {62'd0, frame_err, soft_rst}, {62'd0, mon_e[33:32]});
                    check("event_valid", {63'd0, reg_wr_valid}, {63'd0, mon_e[33:32] != 2'd2});
                    if (mon_e[33:32] != 2'd2) begin
                        check("wr_addr", {60'd0, reg_wr_addr}, {60'd0, mon_e[31:28]});
                        check("wr_data", {36'd0, reg_wr_data}, {36'd0, mon_e[27:0]});
                    end
                end
            end else if (soft_rst) begin
                check("soft_rst_alone", {63'd0, soft_rst}, 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_xfer(input logic [31:0] word, input int nbits, input int gap,
                            output logic [31:0] miso_word);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        miso_word = 32'd0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[31 - (i % 32)];
            spi_sck  = 1'b1;
            repeat (H) @(negedge clk);
            miso_word = {miso_word[30:0], spi_miso};
            spi_sck = 1'b0;
            repeat (H) @(negedge clk);
        end
        spi_cs = 1'b1;
        repeat (gap) @(negedge clk);
        if (gap >= 4) check("miso_idle", {63'd0, spi_miso}, 64'd0);
    endtask

    task automatic run_frame(input logic [31:0] word, input int nbits, input int gap);
        logic [31:0] exp_miso;
        logic [31:0] got;
        exp_miso = model_echo_word();
        model_frame(word, nbits);
        spi_xfer(word, nbits, gap, got);
        if (nbits <= 32) check("miso_word", {32'd0, got}, {32'd0, exp_miso >> (32 - nbits)});
    endtask

    task automatic rd_check(input logic [3:0] a);
        repeat (6) @(negedge clk);
        rd_addr = a;
        #1;
        check("rd_data", {36'd0, rd_data}, {36'd0, m_regs[a]});
    endtask

    task automatic rd_sweep();
        for (int a = 0; a < 16; a++) rd_check(4'(a));
    endtask

    task automatic wait_lock_rise(input string name);
        for (int k = 0; k < 100 && !lock; k++) @(negedge clk);
        check({name, "_seen"}, {63'd0, lock}, 64'd1);
        check({name, "_delay"}, 64'(cyc - commit_cyc), 64'(LD));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, {63'd0, reg_wr_valid}, 64'd0);
        check({name, "_err"},   {63'd0, frame_err},    64'd0);
        check({name, "_soft"},  {63'd0, soft_rst},     64'd0);
        check({name, "_lock"},  {63'd0, lock},         64'd0);
        check({name, "_miso"},  {63'd0, spi_miso},     64'd0);
        check({name, "_waddr"}, {60'd0, reg_wr_addr},  64'd0);
        check({name, "_wdata"}, {36'd0, reg_wr_data},  64'd0);
        check({name, "_rdata"}, {36'd0, rd_data},      64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(8 * 95000);
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [31:0] w;
        int          nb;
        int          gp;

        model_reset();
        repeat (5) @(negedge clk);
        rd_addr = 4'd7;
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
`ifndef PLL_SPI_RESP_LOCK_EN
        check("lock_tied", {63'd0, lock}, 64'd1);
`endif

        // basic write and read-back
        run_frame(32'h40870010, 32, 10);
        rd_check(4'd0);

        // echo of the previously committed address
        run_frame(32'h021FEA0F, 32, 10);
        run_frame(32'h00000004, 32, 10);
        rd_check(4'd15);

        // short and long frames are errors and leave registers alone
        run_frame(32'hDEADBEE2, 31, 10);
        run_frame(32'hCAFEF00D, 33, 10);
        run_frame(32'h13572461, 40, 10);
        rd_sweep();

        // back-to-back frames with the shortest cs-high gap
        run_frame(32'h1111111A, 32, 0);
        run_frame(32'h2222222B, 32, 0);
        run_frame(32'h3333333C, 32, 10);
        rd_check(4'd10);
        rd_check(4'd11);

        // soft reset
        run_frame(32'h2000F3C3, 32, 10);
        rd_check(4'd3);
        run_frame(32'h00000015, 32, 10);
        rd_check(4'd3);
`ifdef PLL_SPI_RESP_LOCK_EN
        check("lock_after_soft", {63'd0, lock}, 64'd0);
`else
        check("lock_after_soft", {63'd0, lock}, 64'd1);
`endif

        // randomized frames
        for (int n = 0; n < 28; n++) begin
            w  = $urandom;
            nb = ($urandom_range(0, 9) < 7) ? 32 : $urandom_range(1, 40);
            gp = $urandom_range(0, 12);
            run_frame(w, nb, gp);
            if (gp >= 6) rd_check(4'($urandom_range(0, 15)));
        end
        rd_sweep();

`ifdef PLL_SPI_RESP_LOCK_EN
        // lock timing and relock on a second R0 write
        run_frame(32'h70100000, 32, 10);
        check("lock_low_after_r0", {63'd0, lock}, 64'd0);
        wait_lock_rise("lock_first");
        repeat (5) @(negedge clk);
        run_frame(32'h00000120, 32, 10);
        check("lock_drop_second_r0", {63'd0, lock}, 64'd0);
        wait_lock_rise("lock_second");
`else
        run_frame(32'h70100000, 32, 10);
        check("lock_tied_r0", {63'd0, lock}, 64'd1);
`endif

        // reset in the middle of a frame
        w = 32'h9ABCDEF0;
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            spi_mosi = w[31 - i];
            spi_sck  = 1'b1;
            repeat (H) @(negedge clk);
            spi_sck = 1'b0;
            repeat (H) @(negedge clk);
        end
        rst_n = 1'b0;
        rd_addr = 4'd0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        run_frame(32'h12345678, 32, 10);
        rd_sweep();

        repeat (20) @(negedge clk);
        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_spi_responder.md
PLL_SPI_RESPONDER -- requirements
Module: pll_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on spi_cs/spi_sck/spi_mosi (legal 2..4).
REQ-002 SHALL have parameter LOCK_DELAY, default 1024, meaning clk cycles from an R0 write to lock assertion (legal 1..2^24-1).
REQ-003 SHALL have ports: clk input 1, system clock (125 MHz); rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports: spi_cs input 1, frame select, active-low; spi_sck input 1, SPI clock, CPOL=0/CPHA=1, at most clk/8; spi_mosi input 1, serial data in, MSB first; spi_miso output 1, serial data out, MSB first.
REQ-005 SHALL have ports: reg_wr_valid output 1, one-cycle commit strobe; reg_wr_addr output 4, register address; reg_wr_data output 28, register payload; frame_err output 1, one-cycle malformed-frame strobe; soft_rst output 1, one-cycle soft-reset strobe; lock output 1, emulated PLL lock.
REQ-006 SHALL have ports: rd_addr input 4, local read address; rd_data output 28, combinational register-file content at rd_addr.

Function
REQ-007 SHALL sample spi_mosi on each synchronized falling spi_sck edge and shift it into a 32-bit register, MSB first, while spi_cs is low.
REQ-008 SHALL drive spi_miso with the next outgoing bit on each synchronized rising spi_sck edge while spi_cs is low, and SHALL hold spi_miso at 0 while spi_cs is high.
REQ-009 SHALL decode a frame as address = bits[3:0], payload = bits[31:4].
REQ-010 SHALL implement states IDLE (cs high), SHIFT (cs low, counting falling edges), COMMIT (one cycle) and ERROR (one cycle); IDLE->SHIFT on cs fall; SHIFT->COMMIT on cs rise with exactly 32 bits; SHIFT->ERROR on cs rise with any other count; COMMIT/ERROR->IDLE.
REQ-011 SHALL saturate the bit counter at 33 so that frames longer than 32 bits route to ERROR.
REQ-012 In COMMIT it SHALL write the payload to the 16x28 register file, pulse reg_wr_valid, and present reg_wr_addr/reg_wr_data in that cycle; reg_wr_valid SHALL pulse no later than SYNC_STAGES+2 clk cycles after the cs rising edge at the pin.
REQ-013 In ERROR it SHALL pulse frame_err and SHALL leave the register file unchanged.
REQ-014 SHALL shift out on spi_miso, during frame N, {reg[A][27:0], A}, where A is the address committed by frame N-1; the first frame after reset returns 32'h0.
REQ-015 SHALL treat a committed write to address 5 with payload bit 0 set as a soft reset: clear every register to 0, pulse soft_rst, deassert lock, and not store the written word.
REQ-016 SHALL ignore spi_sck edges while spi_cs is high.
REQ-017 SHALL restart counting if spi_cs falls in the same cycle that COMMIT or ERROR completes.

Reset
REQ-018 On rst_n low (asynchronous) it SHALL return to IDLE and clear the register file, shift register, bit counter, echo address and lock counter; spi_miso, reg_wr_valid, frame_err, soft_rst and lock SHALL be 0; reg_wr_addr and reg_wr_data SHALL be 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame without commit; after release the block SHALL wait for the next cs fall.

Configuration
REQ-020 With PLL_SPI_RESP_LOCK_EN defined it SHALL restart a counter on every committed address-0 write and assert lock when the counter reaches LOCK_DELAY; lock SHALL clear on any R0 write, soft reset or rst_n.
REQ-021 Without PLL_SPI_RESP_LOCK_EN it SHALL tie lock to 1 after reset release and omit the counter.

Structure
REQ-022 SHALL place the state enum, frame width (32), address width (4), payload width (28) and soft-reset address (5) constants in a shared package, pll_spi_pkg.
REQ-023 SHALL instantiate one sub-module, spi_sync_edge, per SPI input (synchronizer plus rise/fall detect).

Verification
REQ-024 Frame 0x40870010 -> reg_wr_valid once, addr 0x0, data 0x4087001, rd_addr=0 gives 0x4087001.
REQ-025 Frame 0x021FEA0F, then frame 0x00000004 -> spi_miso word during the second frame = 0x021FEA0F.
REQ-026 cs high after 31 bits -> frame_err pulse, no reg_wr_valid, register file unchanged.
REQ-027 Write R3 = 0x2000F3C3, then frame 0x00000015 -> soft_rst pulse, rd_addr=3 gives 0, lock=0.
REQ-028 With PLL_SPI_RESP_LOCK_EN and LOCK_DELAY=16, frame 0x70100000 -> lock rises 16 cycles after commit; a second R0 frame drops lock, then re-locks.
REQ-029 rst_n low at bit 20 of a frame -> all outputs 0, no commit; the next full frame commits normally.
